// File: rtl/spi_accel_pkg.sv
// Shared command defaults and FSM state encoding for the SPI mode-3 register-access target.
// No logic here; nothing to stall.
package spi_accel_pkg;

    localparam logic [7:0] CMD_WRITE_DEF = 8'h0A;
    localparam logic [7:0] CMD_READ_DEF  = 8'h0B;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_WADDR  = 3'd2,
        ST_WDATA  = 3'd3,
        ST_RADDR  = 3'd4,
        ST_RDATA  = 3'd5,
        ST_IGNORE = 3'd6
    } state_t;

endpackage

// File: rtl/spi_accel_slave_sync_edge.sv
// Synchronizes one async input and emits 1-clk rise/fall pulses; pulses lag the pin by STAGES clk.
// No backpressure: every edge produces exactly one pulse.
module spi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;
    logic              w_q;

    assign w_q = r_sync[STAGES-1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= {STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
            r_prev <= w_q;
        end
    end

    assign o_rise = w_q & ~r_prev;
    assign o_fall = ~w_q & r_prev;

endmodule

// File: rtl/spi_accel_slave.sv
// SPI mode-3 target decoding cmd/addr/data bytes into a register-bank port; miso follows SCK fall by <= SYNC_STAGES+1 clk.
// No backpressure: the master paces everything, so the bank must accept reg_we/reg_re every byte.
module spi_accel_slave
    import spi_accel_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] CMD_WRITE   = CMD_WRITE_DEF,
    parameter logic [7:0] CMD_READ    = CMD_READ_DEF
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_cs_n,
    input  logic       i_spi_clk,
    input  logic       i_mosi,
    output logic       o_miso,
    output logic       o_miso_oe,
    output logic [7:0] o_reg_addr,
    output logic [7:0] o_reg_wdata,
    output logic       o_reg_we,
    output logic       o_reg_re,
    input  logic [7:0] i_reg_rdata,
    output logic       o_busy,
    output logic       o_cmd_err
);

    logic w_cs_rise;
    logic w_cs_fall;
    logic w_sck_rise;
    logic w_sck_fall;
    logic w_mosi;
    logic [7:0] w_byte;

    logic [SYNC_STAGES-1:0] r_mosi_sync;
    state_t     r_state;
    logic [2:0] r_bit_cnt;
    logic [6:0] r_rx_shift;
    logic [7:0] r_tx_shift;
    logic       r_miso;
    logic       r_miso_oe;
    logic [7:0] r_reg_addr;
    logic [7:0] r_reg_wdata;
    logic       r_reg_we;
    logic       r_reg_re;
    logic       r_re_d;
    logic       r_cmd_err;

    spi_sync_edge #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_cs_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_cs_n),
        .o_rise  (w_cs_rise),
        .o_fall  (w_cs_fall)
    );

    spi_sync_edge #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sck_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_spi_clk),
        .o_rise  (w_sck_rise),
        .o_fall  (w_sck_fall)
    );

    // Same depth as the SCK chain so the sampled bit lines up with the detected rising edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mosi_sync <= '0;
        end else begin
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
        end
    end

    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];
    assign w_byte = {r_rx_shift, w_mosi};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= 3'd0;
            r_rx_shift  <= 7'd0;
            r_tx_shift  <= 8'd0;
            r_miso      <= 1'b0;
            r_miso_oe   <= 1'b0;
            r_reg_addr  <= 8'd0;
            r_reg_wdata <= 8'd0;
            r_reg_we    <= 1'b0;
            r_reg_re    <= 1'b0;
            r_re_d      <= 1'b0;
            r_cmd_err   <= 1'b0;
        end else begin
            r_reg_we  <= 1'b0;
            r_reg_re  <= 1'b0;
            r_cmd_err <= 1'b0;
            r_re_d    <= r_reg_re;

            if (r_reg_we) begin
                r_reg_addr <= r_reg_addr + 8'd1;
            end
            // Bank answers one clk after reg_re; capture well before the next SCK fall.
            if (r_re_d) begin
                r_tx_shift <= i_reg_rdata;
            end

            // cs_n has priority over any SCK edge seen in the same clk.
            if (w_cs_rise) begin
                r_state    <= ST_IDLE;
                r_miso_oe  <= 1'b0;
                r_miso     <= 1'b0;
                r_bit_cnt  <= 3'd0;
                r_rx_shift <= 7'd0;
            end else if (w_cs_fall) begin
                r_state    <= ST_CMD;
                r_miso_oe  <= 1'b1;
                r_miso     <= 1'b0;
                r_bit_cnt  <= 3'd0;
                r_rx_shift <= 7'd0;
            end else if (r_state != ST_IDLE && r_state != ST_IGNORE) begin
                if (w_sck_fall && r_state == ST_RDATA) begin
                    r_miso     <= r_tx_shift[7];
                    r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                end
                if (w_sck_rise) begin
                    r_rx_shift <= {r_rx_shift[5:0], w_mosi};
                    r_bit_cnt  <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        case (r_state)
                            ST_CMD: begin
                                if (w_byte == CMD_WRITE) begin
                                    r_state <= ST_WADDR;
                                end else if (w_byte == CMD_READ) begin
                                    r_state <= ST_RADDR;
                                end else begin
                                    r_state   <= ST_IGNORE;
                                    r_cmd_err <= 1'b1;
                                end
                            end
                            ST_WADDR: begin
                                r_reg_addr <= w_byte;
                                r_state    <= ST_WDATA;
                            end
                            ST_WDATA: begin
                                r_reg_wdata <= w_byte;
                                r_reg_we    <= 1'b1;
                            end
                            ST_RADDR: begin
                                r_reg_addr <= w_byte;
                                r_reg_re   <= 1'b1;
                                r_state    <= ST_RDATA;
                            end
                            ST_RDATA: begin
                                r_reg_addr <= r_reg_addr + 8'd1;
                                r_reg_re   <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    assign o_miso      = r_miso;
    assign o_miso_oe   = r_miso_oe;
    assign o_reg_addr  = r_reg_addr;
    assign o_reg_wdata = r_reg_wdata;
    assign o_reg_we    = r_reg_we;
    assign o_reg_re    = r_reg_re;
    assign o_cmd_err   = r_cmd_err;
    assign o_busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_spi_accel_slave.sv
// Directed bench: mode-3 SPI master at 50-clk half-period against a 256x8 register bank.
module tb_spi_accel_slave;

    localparam int HP = 50;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cs_n;
    logic       spi_clk;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata = 8'h00;
    logic       busy;
    logic       cmd_err;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    spi_accel_slave dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_cs_n      (cs_n),
        .i_spi_clk   (spi_clk),
        .i_mosi      (mosi),
        .o_miso      (miso),
        .o_miso_oe   (miso_oe),
        .o_reg_addr  (reg_addr),
        .o_reg_wdata (reg_wdata),
        .o_reg_we    (reg_we),
        .o_reg_re    (reg_re),
        .i_reg_rdata (reg_rdata),
        .o_busy      (busy),
        .o_cmd_err   (cmd_err)
    );

    // Behavioural bank: registered read, plus a bench-side preload port.
    logic [7:0] mem [256];
    logic       pre_we = 1'b0;
    logic [7:0] pre_addr = 8'h00;
    logic [7:0] pre_dat = 8'h00;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    end

    always @(negedge clk) begin
        if (pre_we) mem[pre_addr] = pre_dat;
        else if (reg_we) mem[reg_addr] = reg_wdata;
        if (reg_re) reg_rdata = mem[reg_addr];
    end

    // Strobe monitor.
    int         we_cnt = 0;
    int         re_cnt = 0;
    int         err_cnt = 0;
    int         both_cnt = 0;
    logic [7:0] last_we_addr = 8'h00;
    logic [7:0] last_we_dat = 8'h00;
    logic [7:0] re_hist [256];

    always @(negedge clk) begin
        if (rst_n) begin
            if (reg_we) begin
                we_cnt++;
                last_we_addr = reg_addr;
                last_we_dat  = reg_wdata;
            end
            if (reg_re) begin
                if (re_cnt < 256) re_hist[re_cnt] = reg_addr;
                re_cnt++;
            end
            if (cmd_err) err_cnt++;
            if (reg_we && reg_re) both_cnt++;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " miso"},      int'(miso),      0);
        chk({tag, " miso_oe"},   int'(miso_oe),   0);
        chk({tag, " reg_addr"},  int'(reg_addr),  0);
        chk({tag, " reg_wdata"}, int'(reg_wdata), 0);
        chk({tag, " reg_we"},    int'(reg_we),    0);
        chk({tag, " reg_re"},    int'(reg_re),    0);
        chk({tag, " busy"},      int'(busy),      0);
        chk({tag, " cmd_err"},   int'(cmd_err),   0);
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        @(posedge clk);
        pre_addr = a;
        pre_dat  = d;
        pre_we   = 1'b1;
        @(posedge clk);
        pre_we   = 1'b0;
    endtask

    // Mode 3: drive on SCK fall, sample on SCK rise, MSB first.
    task automatic spi_bits(input logic [7:0] tx, input int nb, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nb; i--) begin
            @(negedge clk);
            spi_clk = 1'b0;
            mosi    = tx[i];
            repeat (HP) @(negedge clk);
            spi_clk = 1'b1;
            rx[i]   = miso;
            repeat (HP - 1) @(negedge clk);
        end
    endtask

    task automatic run_frame(input logic [7:0] tx [4], input int n, output logic [7:0] rx [4]);
        logic [7:0] r;
        for (int i = 0; i < 4; i++) rx[i] = 8'h00;
        @(negedge clk);
        cs_n = 1'b0;
        repeat (HP) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            spi_bits(tx[i], 8, r);
            rx[i] = r;
        end
        repeat (HP) @(negedge clk);
        cs_n = 1'b1;
        repeat (HP) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] b0, b1, b2;
        logic       pre_en;
        logic [7:0] pre_dat;
        int         we;
        int         re;
        int         err;
        logic [7:0] addr1;
        logic [7:0] wdat;
        logic [7:0] rx2;
        logic [7:0] addr_end;
    } vec_t;

    vec_t       vecs [7];
    logic [7:0] tbytes [4];
    logic [7:0] rbytes [4];
    logic [7:0] dummy;
    int         we0, re0, err0;

    initial begin
        //           b0     b1     b2    pre   pdat  we re err addr1  wdat   rx2    addr_end
        vecs[0] = '{8'h0A, 8'h1F, 8'h52, 1'b0, 8'h00, 1, 0, 0, 8'h1F, 8'h52, 8'h00, 8'h20};
        vecs[1] = '{8'h0B, 8'h00, 8'h00, 1'b1, 8'hAD, 0, 2, 0, 8'h00, 8'h00, 8'hAD, 8'h01};
        vecs[2] = '{8'h0A, 8'h80, 8'hC3, 1'b0, 8'h00, 1, 0, 0, 8'h80, 8'hC3, 8'h00, 8'h81};
        vecs[3] = '{8'h0B, 8'h80, 8'hFF, 1'b0, 8'h00, 0, 2, 0, 8'h80, 8'h00, 8'hC3, 8'h81};
        vecs[4] = '{8'h55, 8'h01, 8'h00, 1'b0, 8'h00, 0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h81};
        vecs[5] = '{8'h0A, 8'hFF, 8'h7E, 1'b0, 8'h00, 1, 0, 0, 8'hFF, 8'h7E, 8'h00, 8'h00};
        vecs[6] = '{8'h0B, 8'hFF, 8'h00, 1'b0, 8'h00, 0, 2, 0, 8'hFF, 8'h00, 8'h7E, 8'h00};

        rst_n   = 1'b0;
        cs_n    = 1'b1;
        spi_clk = 1'b1;
        mosi    = 1'b0;
        repeat (4) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            if (vecs[v].pre_en) preload(vecs[v].b1, vecs[v].pre_dat);
            we0  = we_cnt;
            re0  = re_cnt;
            err0 = err_cnt;
            tbytes = '{vecs[v].b0, vecs[v].b1, vecs[v].b2, 8'h00};
            run_frame(tbytes, 3, rbytes);
            chk($sformatf("v%0d we_count", v),  we_cnt - we0,   vecs[v].we);
            chk($sformatf("v%0d re_count", v),  re_cnt - re0,   vecs[v].re);
            chk($sformatf("v%0d cmd_err", v),   err_cnt - err0, vecs[v].err);
            if (vecs[v].we > 0) begin
                chk($sformatf("v%0d we_addr", v),  int'(last_we_addr), int'(vecs[v].addr1));
                chk($sformatf("v%0d we_data", v),  int'(last_we_dat),  int'(vecs[v].wdat));
            end
            if (vecs[v].re > 0)
                chk($sformatf("v%0d re_addr", v), int'(re_hist[re0]), int'(vecs[v].addr1));
            chk($sformatf("v%0d rx_byte3", v),  int'(rbytes[2]), int'(vecs[v].rx2));
            chk($sformatf("v%0d addr_end", v),  int'(reg_addr),  int'(vecs[v].addr_end));
            chk($sformatf("v%0d busy_end", v),  int'(busy),      0);
            chk($sformatf("v%0d oe_end", v),    int'(miso_oe),   0);
        end

        // Burst read across the 0xFF -> 0x00 wrap.
        preload(8'hFF, 8'h11);
        preload(8'h00, 8'h22);
        re0 = re_cnt;
        tbytes = '{8'h0B, 8'hFF, 8'h00, 8'h00};
        run_frame(tbytes, 4, rbytes);
        chk("burst byte1", int'(rbytes[2]), 8'h11);
        chk("burst byte2", int'(rbytes[3]), 8'h22);
        chk("burst re_addr0", int'(re_hist[re0]), 8'hFF);
        chk("burst re_addr1", int'(re_hist[re0 + 1]), 8'h00);

        // Abort after 4 bits of write data.
        we0 = we_cnt;
        @(negedge clk);
        cs_n = 1'b0;
        repeat (HP) @(negedge clk);
        spi_bits(8'h0A, 8, dummy);
        spi_bits(8'h10, 8, dummy);
        spi_bits(8'hF0, 4, dummy);
        chk("abort busy_mid", int'(busy), 1);
        chk("abort oe_mid", int'(miso_oe), 1);
        cs_n = 1'b1;
        repeat (HP) @(negedge clk);
        chk("abort we_count", we_cnt - we0, 0);
        chk("abort busy", int'(busy), 0);
        chk("abort oe", int'(miso_oe), 0);
        chk("abort miso", int'(miso), 0);
        tbytes = '{8'h0A, 8'h10, 8'h99, 8'h00};
        run_frame(tbytes, 3, rbytes);
        chk("post_abort we_count", we_cnt - we0, 1);
        chk("post_abort we_addr", int'(last_we_addr), 8'h10);
        chk("post_abort we_data", int'(last_we_dat), 8'h99);

        // Async reset in the middle of a read burst.
        preload(8'h00, 8'hAD);
        @(negedge clk);
        cs_n = 1'b0;
        repeat (HP) @(negedge clk);
        spi_bits(8'h0B, 8, dummy);
        spi_bits(8'h5A, 8, dummy);
        spi_bits(8'h00, 3, dummy);
        chk("pre_reset addr", int'(reg_addr), 8'h5A);
        chk("pre_reset busy", int'(busy), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        cs_n    = 1'b1;
        spi_clk = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        tbytes = '{8'h0B, 8'h00, 8'h00, 8'h00};
        run_frame(tbytes, 3, rbytes);
        chk("post_reset read", int'(rbytes[2]), 8'hAD);

        chk("we_re_overlap", both_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
